// File: rtl/lcd_char_controller.sv
// HD44780 character-LCD driver: power-on init, then refresh of a host-writable ROWS x COLS buffer.
// Latency: every LCD transaction is ISSUE/DROP/HOLD = 3 step ticks of TICK_DIV clocks; a write is visible from the next data ISSUE of its index.
// Backpressure: none; the write port accepts every cycle and the panel is never waited on (RW held 0).
module lcd_char_controller #(
    parameter int TICK_DIV     = 62500,
    parameter int COLS         = 16,
    parameter int ROWS         = 2,
    parameter int HEX_EXPAND   = 1,
    parameter int REFRESH_MODE = 0,
    localparam int NCELL       = ROWS * COLS,
    localparam int AW          = (NCELL > 1) ? $clog2(NCELL) : 1
) (
    input  logic          iCLK_50MHZ,
    input  logic          iRST_N,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          clear_req,
    output logic          ready,
    output logic          frame_done,
    output logic          LCD_RS,
    output logic          LCD_E,
    output logic          LCD_RW,
    inout  wire  [7:0]    DATA_BUS
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [AW:0] NCELL_W = (AW + 1)'(NCELL);

    typedef enum logic [3:0] {
        ST_RESET1,
        ST_RESET2,
        ST_RESET3,
        ST_FUNC_SET,
        ST_DISP_OFF,
        ST_CLEAR,
        ST_DISP_ON,
        ST_MODE_SET,
        ST_HOME,
        ST_DATA,
        ST_ROW_ADDR,
        ST_IDLE
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_DROP,
        PH_HOLD
    } phase_t;

    // Step tick generator
    logic [TW-1:0] tick_cnt;
    logic          tick;

    // Character buffer and dirty flag
    logic [7:0]    char_buf [NCELL];
    logic          wr_ok;
    logic          dirty_q;
    logic          dirty_set;
    logic          dirty_clr;

    // Sequencer state
    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [7:0]    dat_q, dat_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic [7:0]    cur_byte;
    logic [7:0]    shown_byte;
    logic [7:0]    cmd_byte;
    logic [7:0]    row_addr;
    logic          last_col;
    logic          last_row;
    state_t        frame_next;

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign wr_ok     = wr_en && ({1'b0, wr_addr} < NCELL_W);
    assign dirty_set = wr_ok || clear_req;
    assign cur_byte  = char_buf[idx_q];
    assign last_col  = (col_q == CW'(COLS - 1));
    assign last_row  = (row_q == 2'(ROWS - 1));

    assign LCD_E      = e_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign DATA_BUS   = dat_q;
    assign ready      = ready_q;
    assign frame_done = done_q;

    // Free-running 0..TICK_DIV-1 counter producing the one-cycle step enable
    always_ff @(posedge iCLK_50MHZ) begin
        if (!iRST_N) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Buffer writes; a write in the same cycle as a clear lands on top of the blank fill
    always_ff @(posedge iCLK_50MHZ) begin
        if (!iRST_N) begin
            for (int i = 0; i < NCELL; i++) begin
                char_buf[i] <= 8'h20;
            end
        end else begin
            if (clear_req) begin
                for (int i = 0; i < NCELL; i++) begin
                    char_buf[i] <= 8'h20;
                end
            end
            if (wr_ok) begin
                char_buf[wr_addr] <= wr_data;
            end
        end
    end

    // Dirty flag: a host update in the HOME ISSUE cycle keeps it set so the change is not lost
    always_ff @(posedge iCLK_50MHZ) begin
        if (!iRST_N) begin
            dirty_q <= 1'b1;
        end else if (dirty_set) begin
            dirty_q <= 1'b1;
        end else if (dirty_clr) begin
            dirty_q <= 1'b0;
        end
    end

    // DDRAM row start addresses (rows 2/3 continue rows 0/1 after COLS characters)
    always_comb begin
        row_addr = 8'h80;
        unique case (row_q)
            2'd0:    row_addr = 8'h80;
            2'd1:    row_addr = 8'hC0;
            2'd2:    row_addr = 8'h80 + 8'(COLS);
            default: row_addr = 8'hC0 + 8'(COLS);
        endcase
    end

    // Command byte for each non-data state
    always_comb begin
        cmd_byte = 8'h00;
        unique case (state_q)
            ST_RESET1, ST_RESET2, ST_RESET3, ST_FUNC_SET: cmd_byte = 8'h38;
            ST_DISP_OFF: cmd_byte = 8'h08;
            ST_CLEAR:    cmd_byte = 8'h01;
            ST_DISP_ON:  cmd_byte = 8'h0C;
            ST_MODE_SET: cmd_byte = 8'h06;
            ST_HOME:     cmd_byte = 8'h80;
            ST_ROW_ADDR: cmd_byte = row_addr;
            default:     cmd_byte = 8'h00;
        endcase
    end

    // Raw nibbles 0x00-0x0F become ASCII hex digits when expansion is on
    always_comb begin
        shown_byte = cur_byte;
        if (HEX_EXPAND != 0 && cur_byte[7:4] == 4'h0) begin
            if (cur_byte[3:0] <= 4'd9) begin
                shown_byte = 8'h30 + {4'h0, cur_byte[3:0]};
            end else begin
                shown_byte = 8'h37 + {4'h0, cur_byte[3:0]};
            end
        end
    end

    // Where a finished frame goes: straight back to HOME, or wait for new content
    always_comb begin
        frame_next = ST_HOME;
        if (REFRESH_MODE != 0 && !dirty_q) begin
            frame_next = ST_IDLE;
        end
    end

    // Sequencer state and registered panel outputs
    always_ff @(posedge iCLK_50MHZ) begin
        if (!iRST_N) begin
            state_q <= ST_RESET1;
            phase_q <= PH_ISSUE;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            dat_q   <= 8'h00;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            dat_q   <= dat_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Next-state: ISSUE drives the bus and raises E, DROP lowers E, HOLD picks the next command
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        row_d     = row_q;
        col_d     = col_q;
        idx_d     = idx_q;
        e_d       = e_q;
        rs_d      = rs_q;
        dat_d     = dat_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        dirty_clr = 1'b0;
        if (tick) begin
            unique case (phase_q)
                PH_ISSUE: begin
                    if (state_q == ST_IDLE) begin
                        if (dirty_q) begin
                            state_d = ST_HOME;
                        end
                    end else if (state_q == ST_DATA && cur_byte == 8'hFE) begin
                        // Terminator: nothing is sent, the frame closes here
                        done_d  = 1'b1;
                        state_d = frame_next;
                        row_d   = '0;
                        col_d   = '0;
                        idx_d   = '0;
                    end else begin
                        e_d       = 1'b1;
                        rs_d      = (state_q == ST_DATA);
                        dat_d     = (state_q == ST_DATA) ? shown_byte : cmd_byte;
                        dirty_clr = (state_q == ST_HOME);
                        phase_d   = PH_DROP;
                    end
                end
                PH_DROP: begin
                    e_d     = 1'b0;
                    phase_d = PH_HOLD;
                end
                PH_HOLD: begin
                    phase_d = PH_ISSUE;
                    unique case (state_q)
                        ST_RESET1:   state_d = ST_RESET2;
                        ST_RESET2:   state_d = ST_RESET3;
                        ST_RESET3:   state_d = ST_FUNC_SET;
                        ST_FUNC_SET: state_d = ST_DISP_OFF;
                        ST_DISP_OFF: state_d = ST_CLEAR;
                        ST_CLEAR:    state_d = ST_DISP_ON;
                        ST_DISP_ON:  state_d = ST_MODE_SET;
                        ST_MODE_SET: begin
                            ready_d = 1'b1;
                            state_d = frame_next;
                        end
                        ST_HOME, ST_ROW_ADDR: state_d = ST_DATA;
                        ST_DATA: begin
                            idx_d = idx_q + 1'b1;
                            if (!last_col) begin
                                col_d = col_q + 1'b1;
                            end else if (!last_row) begin
                                col_d   = '0;
                                row_d   = row_q + 1'b1;
                                state_d = ST_ROW_ADDR;
                            end else begin
                                done_d  = 1'b1;
                                state_d = frame_next;
                                row_d   = '0;
                                col_d   = '0;
                                idx_d   = '0;
                            end
                        end
                        default: state_d = state_q;
                    endcase
                end
                default: phase_d = PH_ISSUE;
            endcase
        end
    end

endmodule

// File: doc/lcd_char_controller.md
Name: lcd_char_controller

Overview:
- Parametrised HD44780 character-LCD driver; successor to the fixed 16x2 string-table LCD block.
- Holds a host-writable ROWS x COLS character buffer and runs the power-on init sequence.
- Refreshes the panel either continuously or only when the buffer is dirty.
- Expands raw nibbles to ASCII hex when enabled; game logic writes characters instead of editing a lookup table.

Parameters:
TICK_DIV, 62500, iCLK_50MHZ cycles per LCD step tick (>=2; 62500 gives 800 steps/s, 1.25 ms per step)
COLS, 16, characters per row (1..20)
ROWS, 2, rows (1, 2 or 4)
HEX_EXPAND, 1, 1: buffer bytes 0x00-0x0F are printed as ASCII hex digits
REFRESH_MODE, 0, 0: continuous refresh; 1: refresh only when dirty

Ports:
iCLK_50MHZ  in  1  system clock
iRST_N  in  1  reset, synchronous, active-low
wr_en  in  1  buffer write strobe
wr_addr  in  $clog2(ROWS*COLS)  buffer index, row-major (row*COLS+col)
wr_data  in  8  character byte
clear_req  in  1  one-cycle pulse: fill buffer with 0x20
ready  out  1  init sequence complete
frame_done  out  1  one-cycle pulse when a full frame has been written
LCD_RS  out  1  register select (0 = command, 1 = data)
LCD_E  out  1  enable strobe
LCD_RW  out  1  read/write; held 0 (write only)
DATA_BUS  inout  8  LCD data bus, always driven (RW = 0)

Behaviour:
- One clock, iCLK_50MHZ; synchronous active-low reset iRST_N. The step tick is a 1-cycle enable from a 0..TICK_DIV-1 counter, not a derived clock.
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, DATA_BUS=0x00, ready=0, frame_done=0, tick counter=0, all buffer entries=0x20, dirty=1, FSM=RESET1.
- Reset asserted mid-command drops LCD_E=0 in the same cycle and restarts from RESET1.
- Every LCD transaction takes 3 ticks:
  - ISSUE: E=1 with RS and DATA set.
  - DROP: E=0.
  - HOLD: advance to the next command.
- Init order: RESET1/2/3 0x38 -> FUNC_SET 0x38 -> DISP_OFF 0x08 -> CLEAR 0x01 -> DISP_ON 0x0C -> MODE_SET 0x06.
  - This is 8 transactions = 24 ticks.
  - ready rises on the MODE_SET HOLD tick and stays 1 until reset.
- Frame sequence: HOME (row-0 address) -> COLS data writes -> next row address -> ... -> last row.
  - Row DDRAM addresses: row0 0x80, row1 0xC0, row2 0x80+COLS, row3 0xC0+COLS.
  - Row 0 address is issued as HOME.
- Frame start:
  - REFRESH_MODE=0: a new frame starts immediately after the previous one.
  - REFRESH_MODE=1: FSM waits in IDLE (E=0) until dirty=1.
- Dirty flag:
  - Cleared on the HOME ISSUE tick.
  - Set by any wr_en or clear_req.
  - A set in the same cycle as the clear wins (dirty stays 1).
- Terminator: byte 0xFE is not sent. The frame ends immediately, frame_done pulses, and the next frame restarts at HOME.
- Hex expansion (HEX_EXPAND=1, byte[7:4]==0):
  - n<=9 sends 0x30+n.
  - n>=10 sends 0x41+(n-10).
  - HEX_EXPAND=0 sends the byte unchanged.
- Buffer data is sampled at the data ISSUE tick. Writes landing mid-frame appear in this frame only if their index has not been sent yet.
- Write port:
  - Writes are accepted every cycle, including during init.
  - wr_addr >= ROWS*COLS is ignored and does not set dirty.
  - clear_req with wr_en in the same cycle: buffer is cleared and the write still lands.
- frame_done: one iCLK_50MHZ cycle, on the HOLD tick of the last data write, or on the terminator.
- Timing at TICK_DIV=62500: 16x2 frame = 102 ticks. CLEAR has >=2 ticks of settle (2.5 ms > 1.52 ms).

Test Plan:
1. TICK_DIV=4, reset low 3 cycles then high -> DATA_BUS sequence 38,38,38,38,08,01,0C,06 with RS=0; each E=1 for exactly 4 cycles; ready=1 after tick 24.
2. Write "HI" to addr 0..1, rest default -> frame bytes 80,48,49,20x14,C0,20x16; frame_done pulses once at tick 102 after frame start.
3. HEX_EXPAND=1; write 0x0A, 0x07, 0x0F, 0x41 -> LCD data 0x41, 0x37, 0x46, 0x41. HEX_EXPAND=0 -> 0x0A, 0x07, 0x0F, 0x41.
4. Write 0xFE at addr 3 -> three data writes then frame_done; next transaction is HOME 0x80.
5. REFRESH_MODE=1: after one frame, FSM idles with E=0 for 1000 ticks. wr_en coinciding with the HOME ISSUE tick -> a second frame follows.
6. ROWS=4, COLS=20 -> row addresses 0x80, 0xC0, 0x94, 0xD4. Assert reset mid-frame with E=1 -> E=0 next cycle, init restarts, buffer returns to 0x20.
